// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared FSM state type, default widths and counter sizing for tx_arbiter.
package tx_arb_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int WDOG_CYCLES_DEF = 64;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    localparam int WDOG_W_DEF = cnt_w(WDOG_CYCLES_DEF);
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr with wraparound.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] win,
    output logic         any
);
    always_comb begin
        win = ptr;
        // scan farthest offset first so the closest one to ptr wins
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) win = W'((int'(ptr) + k) % N);
    end
    assign any = |req;
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler feeding one serial transmitter with enforced idle gap.
// Optional SEND watchdog enabled by defining TX_ARB_WDOG_EN.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int GAP_CYCLES  = 2,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      Clk_s,
    input  logic                      Rst_n,
    input  logic [NUM_REQ-1:0]        Req_Valid,
    input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
    output logic [NUM_REQ-1:0]        Req_Ack,
    output logic                      TxData_Valid,
    output logic [DATA_W-1:0]         TxData,
    input  logic                      Tx_Ready,
    output logic [ID_W-1:0]           Grant_Id,
    output logic                      Arb_Busy,
    output logic                      Arb_Error,
    output logic [ID_W-1:0]           Err_Id
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, win;
    logic              any, grant, xfer, wdog_fire, send_done;
    logic [GAP_W-1:0]  gap_cnt;

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req(Req_Valid),
        .ptr(ptr),
        .win(win),
        .any(any)
    );

    assign xfer      = TxData_Valid && Tx_Ready;
    assign send_done = (state == SEND) && (xfer || wdog_fire);

    always_ff @(posedge Clk_s or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && any)            state_nxt = SEND;
        else if (send_done)                  state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        else if (state == GAP && gap_cnt <= 1) state_nxt = IDLE;
    end

    always_comb begin
        grant    = (state == IDLE) && any;
        Arb_Busy = (state != IDLE);
    end

    always_ff @(posedge Clk_s or negedge Rst_n) begin
        if (!Rst_n) begin
            Req_Ack      <= '0;
            TxData_Valid <= 1'b0;
            TxData       <= '0;
            Grant_Id     <= '0;
            ptr          <= '0;
            gap_cnt      <= '0;
        end else begin
            Req_Ack <= '0;
            if (grant) begin
                TxData       <= Req_Data[int'(win)*DATA_W +: DATA_W];
                TxData_Valid <= 1'b1;
                Grant_Id     <= win;
                Req_Ack[win] <= 1'b1;
                ptr          <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (send_done) TxData_Valid <= 1'b0;
            gap_cnt <= (state == SEND) ? GAP_W'(GAP_CYCLES) : (state == GAP) ? gap_cnt - 1'b1 : gap_cnt;
        end
    end

`ifdef TX_ARB_WDOG_EN
    localparam int WDOG_W = cnt_w(WDOG_CYCLES);
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_fire = (state == SEND) && !xfer && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge Clk_s or negedge Rst_n) begin
        if (!Rst_n) begin
            wdog_cnt  <= '0;
            Arb_Error <= 1'b0;
            Err_Id    <= '0;
        end else begin
            wdog_cnt  <= (state == SEND) ? wdog_cnt + 1'b1 : '0;
            Arb_Error <= wdog_fire;
            Err_Id    <= wdog_fire ? Grant_Id : Err_Id;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign Arb_Error = 1'b0;
    assign Err_Id    = '0;
`endif
endmodule
